result_serializer: RTL

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/alu_pkg.sv | 18 +
 rtl/result_serializer_if.sv | 29 ++
 rtl/byte_select.sv | 15 +
 rtl/result_serializer.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the result serializer slice.
package alu_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NBYTES = DEF_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-byte word still needs a one-bit index port.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Load side and byte-stream side of the result serializer.
interface result_serializer_if #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH
);
  localparam int IW = alu_pkg::idx_width(WIDTH / 8);

  logic             load;
  logic [WIDTH-1:0] din;
  logic             carry_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             out_carry;
  logic             done;

  modport master (
    output load, din, carry_in, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, out_carry, done
  );

  modport slave (
    input  load, din, carry_in, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, out_carry, done
  );

endinterface

// File: rtl/byte_select.sv
// Combinational byte mux: picks byte idx of word, byte 0 = bits [7:0].
module byte_select
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IW    = idx_width(DEF_WIDTH / 8)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IW-1:0]    idx,
  output logic [7:0]       byte_out
);

  assign byte_out = word[{idx, 3'b000} +: 8];

endmodule

// File: rtl/result_serializer.sv
// Captures a result word plus carry and streams it out LSB byte first.
//
// state | meaning
// IDLE  | waiting for load; word and carry hold last capture
// SEND  | presenting byte idx, advancing on each accepted transfer
// DONE  | one-cycle completion pulse, then back to IDLE
module result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  result_serializer_if.slave bus
);

  localparam int            NBYTES   = WIDTH / 8;
  localparam int            IW       = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             valid_q;
  logic             last_q;
  logic             done_q;
  logic             busy_q;
  logic [7:0]       sel_byte;

  byte_select #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_byte_select (
    .word     (word),
    .idx      (idx),
    .byte_out (sel_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            word    <= bus.din;
            carry   <= bus.carry_in;
            idx     <= '0;
            state   <= SEND;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= (LAST_IDX == '0);
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (idx == LAST_IDX) begin
              // idx parks on the last byte; it is cleared by the next load.
              state   <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx    <= idx + IW'(1);
              last_q <= ((idx + IW'(1)) == LAST_IDX);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Byte output is forced low whenever nothing is being offered.
  assign bus.out_data  = valid_q ? sel_byte : 8'h00;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx;
  assign bus.out_last  = last_q;
  assign bus.out_carry = carry;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule
